// File: rtl/instruction_fetch.sv
// instruction_fetch: issues word fetches to instruction memory and queues returned words for decode.
// Latency: a grant in cycle N with rvalid in N+1 gives if_valid in N+2; the buffer never bypasses.
// Backpressure: credits stop requests once buffered entries plus outstanding requests reach BUF_DEPTH.
//
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   imem_req/imem_addr/imem_gnt        fetch request channel (address word-aligned)
//   imem_rvalid/imem_rdata             in-order read response channel
//   redirect_valid/redirect_pc         control-flow redirect (flushes buffer, discards in-flight)
//   if_valid/if_instr/if_pc/id_ready   instruction handoff to decode
// Optional feature macro: IF_JUMP_PREDECODE_EN (a transferred J-type word, opcode 6'h02,
// redirects fetch internally; an external redirect in the same cycle wins).
module instruction_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        id_ready
);

  // Storage is sized for the largest legal depth; only BUF_DEPTH slots are ever used.
  logic [31:0] buf_instr [4];
  logic [31:0] buf_pc    [4];

  logic [31:0] fetch_pc;   // next address to request
  logic [31:0] resp_pc;    // address of the next response that will be kept
  logic [2:0]  buf_cnt;
  logic [2:0]  out_cnt;    // requests granted but not yet answered (kept + discarded)
  logic [2:0]  disc_cnt;   // leading outstanding responses that must be dropped
  logic [1:0]  rd_ptr;
  logic [1:0]  wr_ptr;
  logic        started;    // holds off requests until the first edge after reset release

  logic        pop;
  logic        grant;
  logic        rsp_ok;
  logic        rsp_drop;
  logic        push;
  logic        redir;
  logic [31:0] redir_tgt;
  logic [2:0]  occ;
  logic [2:0]  out_nxt;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'(BUF_DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction

  assign if_valid  = (buf_cnt != 3'd0);
  assign if_instr  = if_valid ? buf_instr[rd_ptr] : 32'h0;
  assign if_pc     = if_valid ? buf_pc[rd_ptr]    : 32'h0;
  assign pop       = if_valid & id_ready;
  assign imem_addr = {fetch_pc[31:2], 2'b00};

`ifdef IF_JUMP_PREDECODE_EN
  logic        jump_take;
  logic [31:0] pc_plus4;
  assign pc_plus4  = if_pc + 32'd4;
  assign jump_take = pop & (if_instr[31:26] == 6'h02) & ~redirect_valid;
  assign redir     = redirect_valid | jump_take;
  assign redir_tgt = redirect_valid ? redirect_pc
                                    : {pc_plus4[31:28], if_instr[25:0], 2'b00};
`else
  assign redir     = redirect_valid;
  assign redir_tgt = redirect_pc;
`endif

  // The entry leaving this cycle frees its slot immediately, so a steady stream
  // with id_ready=1 keeps one request in flight per cycle.
  assign occ      = buf_cnt - {2'b00, pop} + out_cnt;
  assign imem_req = started & ~redir & (occ < 3'(BUF_DEPTH));
  assign grant    = imem_req & imem_gnt;

  // A response with nothing outstanding (e.g. left over from before reset) is ignored.
  assign rsp_ok   = imem_rvalid & (out_cnt != 3'd0);
  assign rsp_drop = rsp_ok & (disc_cnt != 3'd0);
  assign push     = rsp_ok & ~rsp_drop & ~redir;
  assign out_nxt  = out_cnt + {2'b00, grant} - {2'b00, rsp_ok};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      buf_cnt  <= 3'd0;
      out_cnt  <= 3'd0;
      disc_cnt <= 3'd0;
      rd_ptr   <= 2'd0;
      wr_ptr   <= 2'd0;
      started  <= 1'b0;
    end else begin
      started <= 1'b1;
      out_cnt <= out_nxt;
      if (redir) begin
        // Everything still in flight after this edge belongs to the old path.
        buf_cnt  <= 3'd0;
        rd_ptr   <= 2'd0;
        wr_ptr   <= 2'd0;
        fetch_pc <= redir_tgt;
        resp_pc  <= redir_tgt;
        disc_cnt <= out_nxt;
      end else begin
        if (grant)    fetch_pc <= fetch_pc + 32'd4;
        if (rsp_drop) disc_cnt <= disc_cnt - 3'd1;
        if (push) begin
          wr_ptr  <= ptr_inc(wr_ptr);
          resp_pc <= resp_pc + 32'd4;
        end
        if (pop) rd_ptr <= ptr_inc(rd_ptr);
        buf_cnt <= buf_cnt + {2'b00, push} - {2'b00, pop};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_instr[wr_ptr] <= imem_rdata;
      buf_pc[wr_ptr]    <= {resp_pc[31:2], 2'b00};
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: vector table, directed corner sequences and random traffic
// checked against a queue-based model of the fetch stream.
module tb_instruction_fetch;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req, imem_gnt, imem_rvalid, redirect_valid, if_valid, id_ready;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, if_instr, if_pc;

  // Second instance: wrap-around reset PC, deepest buffer, always granted, never answered.
  logic        req_b, gnt_b, rvalid_b, redir_b, vld_b, rdy_b;
  logic [31:0] addr_b, rdata_b, rpc_b, instr_b, pc_b;

  always #5 clk = ~clk;

  instruction_fetch #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .id_ready(id_ready));

  instruction_fetch #(.RESET_PC(32'hFFFF_FFF8), .BUF_DEPTH(4)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .imem_req(req_b), .imem_addr(addr_b),
    .imem_gnt(gnt_b), .imem_rvalid(rvalid_b), .imem_rdata(rdata_b),
    .redirect_valid(redir_b), .redirect_pc(rpc_b),
    .if_valid(vld_b), .if_instr(instr_b), .if_pc(pc_b), .id_ready(rdy_b));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [31:0] addr; bit stale; } pend_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  pend_t       pend_q[$];   // granted, unanswered requests in order
  ent_t        fifo_q[$];   // words decode should see, in order
  logic [31:0] exp_fetch;
  int          data_mode = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (data_mode == 0) return 32'h2001_0005;
    if (data_mode == 2) return (a == 32'h1000_0010) ? 32'h0800_0040 : {6'h0F, a[25:0]};
    return a ^ 32'h5A3C_96E1;
  endfunction

  // One clock: drive at the falling edge, check after settling, then advance the model
  // by what the coming rising edge does.
  task automatic cycle(input bit g, input bit rv, input bit rdy, input bit rd,
                       input logic [31:0] rpc);
    bit          xfer, jump, redir, exp_req;
    logic [31:0] tgt, pc4;
    pend_t       p;
    @(negedge clk);
    imem_gnt = g; id_ready = rdy; redirect_valid = rd; redirect_pc = rpc;
    if (rv && pend_q.size() > 0) begin
      imem_rvalid = 1'b1; imem_rdata = mem_word(pend_q[0].addr);
    end else begin
      imem_rvalid = 1'b0; imem_rdata = $urandom;
    end
    #1;
    chk1("if_valid", if_valid, fifo_q.size() != 0);
    if (fifo_q.size() > 0) begin
      chk("if_pc", if_pc, fifo_q[0].pc);
      chk("if_instr", if_instr, fifo_q[0].instr);
    end
    xfer = (fifo_q.size() > 0) && rdy;
    jump = 1'b0;
    tgt  = {rpc[31:2], 2'b00};
    pc4  = 32'h0;
`ifdef IF_JUMP_PREDECODE_EN
    if (xfer && !rd && fifo_q[0].instr[31:26] == 6'h02) begin
      jump = 1'b1;
      pc4  = fifo_q[0].pc + 32'd4;
      tgt  = {pc4[31:28], fifo_q[0].instr[25:0], 2'b00};
    end
`endif
    redir   = rd || jump;
    exp_req = !redir && (fifo_q.size() - (xfer ? 1 : 0) + pend_q.size() < DEPTH);
    chk1("imem_req", imem_req, exp_req);
    if (imem_req) chk("imem_addr", imem_addr, exp_fetch);
    if (xfer) void'(fifo_q.pop_front());
    if (imem_rvalid) begin
      p = pend_q.pop_front();
      if (!p.stale) fifo_q.push_back('{pc: p.addr, instr: imem_rdata});
    end
    if (imem_req && g) begin
      pend_q.push_back('{addr: exp_fetch, stale: 1'b0});
      exp_fetch = exp_fetch + 32'd4;
    end
    if (redir) begin
      fifo_q.delete();
      foreach (pend_q[i]) pend_q[i].stale = 1'b1;
      exp_fetch = tgt;
    end
  endtask

  task automatic do_reset(input bit late_rv);
    @(negedge clk);
    rst_n = 1'b0; imem_gnt = 1'b0; id_ready = 1'b0; redirect_valid = 1'b0;
    imem_rvalid = late_rv; imem_rdata = 32'h2001_0005;
    #1;
    chk1("rst_req", imem_req, 1'b0);
    chk1("rst_if_valid", if_valid, 1'b0);
    chk("rst_if_instr", if_instr, 32'h0);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_wrap_addr", addr_b, 32'hFFFF_FFF8);
    @(negedge clk);
    imem_rvalid = 1'b0;
    @(negedge clk);
    pend_q.delete(); fifo_q.delete(); exp_fetch = 32'h0;
    rst_n = 1'b1;
    #1;
    chk1("req_at_release", imem_req, 1'b0);
  endtask

  typedef struct {
    bit rst; bit g; bit rv; bit rdy;
    bit e_req; logic [31:0] e_addr; bit e_vld; logic [31:0] e_pc;
  } vec_t;
  vec_t vt[14];

  logic [31:0] wrap_addr[4];
  logic [31:0] nxt_pc;
  int          grants;
  bit          seen, got;

  initial begin
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0; redirect_valid = 0; redirect_pc = 0;
    id_ready = 0; exp_fetch = 0;
    gnt_b = 1; rvalid_b = 0; rdata_b = 0; redir_b = 0; rpc_b = 0; rdy_b = 1;

    // Rows 0-4: streaming from reset, one word per cycle.
    // Rows 5-13: decode stalled for six cycles from reset, then released.
    vt[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h0};
    vt[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h04, 1'b0, 32'h0};
    vt[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h0};
    vt[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h4};
    vt[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h8};
    vt[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h00, 1'b0, 32'h0};
    vt[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h04, 1'b0, 32'h0};
    for (int i = 7; i <= 10; i++) vt[i] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0};
    vt[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h0};
    vt[12] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h4};
    vt[13] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h8};

    grants = 0;
    for (int i = 0; i < 14; i++) begin
      if (vt[i].rst) do_reset(1'b0);
      cycle(vt[i].g, vt[i].rv, vt[i].rdy, 1'b0, 32'h0);
      chk1($sformatf("vec%0d_req", i), imem_req, vt[i].e_req);
      if (vt[i].e_req) chk($sformatf("vec%0d_addr", i), imem_addr, vt[i].e_addr);
      chk1($sformatf("vec%0d_vld", i), if_valid, vt[i].e_vld);
      if (vt[i].e_vld) begin
        chk($sformatf("vec%0d_pc", i), if_pc, vt[i].e_pc);
        chk($sformatf("vec%0d_instr", i), if_instr, 32'h2001_0005);
      end
      if (i >= 5 && i <= 10 && imem_req && vt[i].g) grants++;
    end
    chk("stall_grants", grants, DEPTH);

    // Redirect with two requests in flight: both responses dropped.
    do_reset(1'b0);
    cycle(1, 0, 1, 0, 0);
    cycle(1, 0, 1, 0, 0);
    cycle(1, 0, 1, 1, 32'h0000_0103);
    chk1("redir_cycle_req", imem_req, 1'b0);
    cycle(0, 1, 1, 0, 0);
    chk1("discard1_vld", if_valid, 1'b0);
    cycle(0, 1, 1, 0, 0);
    chk1("discard2_vld", if_valid, 1'b0);
    chk1("post_redir_req", imem_req, 1'b1);
    chk("post_redir_addr", imem_addr, 32'h0000_0100);
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      cycle(1, 1, 1, 0, 0);
      if (if_valid) begin got = 1; chk("first_pc_after_redir", if_pc, 32'h100); end
    end
    if (!got) chk("redir_deliver_timeout", 32'h0, 32'h1);

    // Jump word: predecode redirects, plain build passes it through.
    data_mode = 2;
    cycle(0, 0, 1, 1, 32'h1000_0010);
    seen = 0; got = 0; nxt_pc = 32'h0;
    for (int i = 0; i < 40 && !got; i++) begin
      cycle(1, 1, 1, 0, 0);
      if (if_valid) begin
        if (seen) begin got = 1; nxt_pc = if_pc; end
        else if (if_pc == 32'h1000_0010) seen = 1;
      end
    end
`ifdef IF_JUMP_PREDECODE_EN
    chk("jump_next_pc", got ? nxt_pc : 32'hDEAD_BEEF, 32'h1000_0100);
`else
    chk("jump_next_pc", got ? nxt_pc : 32'hDEAD_BEEF, 32'h1000_0014);
`endif

    // Reset PC near the top of the address space wraps to zero.
    data_mode = 0;
    do_reset(1'b0);
    wrap_addr[0] = 32'hFFFF_FFF8; wrap_addr[1] = 32'hFFFF_FFFC;
    wrap_addr[2] = 32'h0000_0000; wrap_addr[3] = 32'h0000_0004;
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 1, 0, 0);
      chk1($sformatf("wrap%0d_req", i), req_b, i < 4);
      if (i < 4) chk($sformatf("wrap%0d_addr", i), addr_b, wrap_addr[i]);
    end

    // Reset while requests are outstanding, late response arriving during reset.
    cycle(1, 0, 1, 0, 0);
    cycle(1, 0, 1, 0, 0);
    do_reset(1'b1);
    cycle(1, 1, 1, 0, 0);
    chk1("restart_req", imem_req, 1'b1);
    chk("restart_addr", imem_addr, 32'h0);
    chk1("restart_vld", if_valid, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1, 1, 1, 0, 0);

    // Random traffic against the model.
    data_mode = 1;
    do_reset(1'b0);
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(99) < 60, $urandom_range(99) < 50, $urandom_range(99) < 65,
            $urandom_range(99) < 3, $urandom);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded at reset.
REQ-002 Parameter BUF_DEPTH, default 2: instruction buffer entries, legal range 2..4.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 imem_req  output  1  fetch request valid.
REQ-006 imem_addr  output  32  fetch byte address, word-aligned.
REQ-007 imem_gnt  input  1  request accepted this cycle when imem_req=1.
REQ-008 imem_rvalid  input  1  read data valid; in-order, at least 1 cycle after grant.
REQ-009 imem_rdata  input  32  instruction word.
REQ-010 redirect_valid  input  1  control-flow redirect strobe.
REQ-011 redirect_pc  input  32  redirect target.
REQ-012 if_valid  output  1  if_instr/if_pc hold a valid instruction for decode.
REQ-013 if_instr  output  32  instruction word to decode.
REQ-014 if_pc  output  32  byte address of if_instr.
REQ-015 id_ready  input  1  decode accepts; transfer when if_valid & id_ready.

Function
REQ-016 The block SHALL keep fetch_pc; imem_addr SHALL equal fetch_pc with bits [1:0] forced to 0.
REQ-017 imem_req SHALL assert only when buffered entries plus outstanding requests < BUF_DEPTH (credit rule), so a response never overflows the buffer.
REQ-018 On imem_req & imem_gnt, fetch_pc SHALL advance by 4 modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000) and the outstanding count SHALL increment.
REQ-019 imem_addr SHALL stay stable while imem_req=1 and imem_gnt=0.
REQ-020 On imem_rvalid, the outstanding count SHALL decrement and {imem_rdata, address} SHALL be written to the buffer tail, unless the response is marked for discard.
REQ-021 The buffer SHALL be a FIFO; if_valid SHALL be 1 iff the buffer is non-empty; if_instr/if_pc SHALL show the head and stay stable until transferred.
REQ-022 Minimum latency: a grant in cycle N followed by rvalid in N+1 SHALL give if_valid=1 in N+2.
REQ-023 Simultaneous push and pop with the buffer full SHALL be legal and keep the count unchanged; a simultaneous push and pop with the buffer empty SHALL NOT bypass (data appears next cycle).
REQ-024 When redirect_valid=1, the cycle's head transfer (if_valid & id_ready) SHALL still complete; then all buffer entries SHALL be flushed, fetch_pc SHALL load {redirect_pc[31:2],2'b00}, and every request outstanding at that edge SHALL be marked for discard.
REQ-025 A grant in the same cycle as redirect_valid SHALL be counted as outstanding and discarded; the next request SHALL use the new PC in the following cycle.
REQ-026 Discarded responses SHALL decrement the outstanding count and never write the buffer; a second redirect before the discards drain SHALL add to the discard count.
REQ-027 No request SHALL issue in the cycle redirect_valid=1.

Reset
REQ-028 While rst_n=0: fetch_pc=RESET_PC, buffer empty, outstanding and discard counts 0, imem_req=0, if_valid=0, if_instr=0, if_pc=0.
REQ-029 Reset asserted mid-transaction SHALL abandon all in-flight requests; the first request after deassertion SHALL issue no earlier than the first rising edge with rst_n=1.

Configuration
REQ-030 Macro IF_JUMP_PREDECODE_EN: when defined, a transferred head whose if_instr[31:26]=6'h02 SHALL act as an internal redirect to {if_pc[31:28]+carry of if_pc+4, if_instr[25:0], 2'b00}, i.e. {(if_pc+4)[31:28], adr, 2'b00}, with the same flush/discard rules as REQ-024; an external redirect_valid in the same cycle SHALL take priority.
REQ-031 Without IF_JUMP_PREDECODE_EN: opcode 6'h02 SHALL be passed through like any other word, with no internal redirect logic.

Verification
REQ-032 Reset release, rdata=0x2001_0005 one cycle after each grant, id_ready=1 -> if_pc=0x0,0x4,0x8 on consecutive cycles, if_instr=0x2001_0005.
REQ-033 id_ready=0 for 6 cycles with gnt=1 -> exactly BUF_DEPTH grants, imem_req=0 thereafter, no buffer overflow, head held stable.
REQ-034 redirect_pc=0x0000_0103 with 2 requests outstanding -> both responses dropped, next imem_addr=0x0000_0100, first if_pc after redirect=0x100.
REQ-035 RESET_PC=0xFFFF_FFF8 -> addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
REQ-036 With IF_JUMP_PREDECODE_EN, if_pc=0x1000_0010 holding instr 0x0800_0040 accepted -> next delivered if_pc=0x1000_0100; without the macro -> next if_pc=0x1000_0014.
REQ-037 rst_n pulsed low while a request is outstanding, late rvalid ignored -> if_valid=0 and fetch restarts at RESET_PC.
